// File: rtl/core_c1_pkg.sv
// rtl/core_c1_pkg.sv - shared encodings for the C1 core data-memory arbiter
package core_c1_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_EXU = 2'd1;
  localparam logic [1:0] ST_RD_EXT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RD_EXU = ST_RD_EXU,
    RD_EXT = ST_RD_EXT
  } dmem_state_e;

  // Memory access size encodings
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/core_c1_dmem_arb.sv
// rtl/core_c1_dmem_arb.sv - data-memory port arbiter and access sequencer for the C1 core
module core_c1_dmem_arb
  import core_c1_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exu_mem_req,
  input  logic        exu_mem_we,
  input  logic [31:0] exu_mem_addr,
  input  logic [31:0] exu_mem_wdata,
  input  logic [1:0]  exu_mem_size,
  output logic [31:0] exu_mem_rdata,
  output logic        exu_pause,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [1:0]  ext_size,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned    CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_MAX);

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          port_free;
  logic          grant_ext;
  logic          grant_exu;

  // Arbitration: a starved or uncontested external request beats the EXU.
  // No strobe is issued while reset is asserted, so a held request cannot
  // touch memory before the FSM is running.
  always_comb begin
    port_free = rst_n && (state_q == IDLE);
    grant_ext = port_free && ext_req && ((starve_cnt_q == CNT_MAX) || !exu_mem_req);
    grant_exu = port_free && !grant_ext && exu_mem_req;
  end

  // Port mux, read-data routing, pause generation and next state
  always_comb begin
    state_d       = state_q;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    mem_size      = SZ_B;
    exu_mem_rdata = 32'd0;
    ext_rdata     = 32'd0;
    ext_rvalid    = 1'b0;
    ext_gnt       = grant_ext;

    if (grant_ext) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_size  = ext_size;
      if (!ext_we) state_d = RD_EXT;
    end else if (grant_exu) begin
      mem_en    = 1'b1;
      mem_we    = exu_mem_we;
      mem_addr  = exu_mem_addr;
      mem_wdata = exu_mem_wdata;
      mem_size  = exu_mem_size;
      if (!exu_mem_we) state_d = RD_EXU;
    end

    // Data-return cycles: the port stays quiet and the returning word goes
    // to whoever issued the read.
    case (state_q)
      RD_EXU: begin
        exu_mem_rdata = mem_rdata;
        state_d       = IDLE;
      end
      RD_EXT: begin
        ext_rdata  = mem_rdata;
        ext_rvalid = 1'b1;
        state_d    = IDLE;
      end
      default: ;
    endcase

    // The EXU may retire only on a granted store or on its load-data cycle
    exu_pause = exu_mem_req && !((grant_exu && exu_mem_we) || (state_q == RD_EXU));
  end

  // Starvation counter next value: cleared on grant, saturating count of refusals
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_ext) begin
      starve_cnt_d = '0;
    end else if (ext_req && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // FSM state register; reset drops any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_core_c1_dmem_arb.sv
// tb/tb_core_c1_dmem_arb.sv - scoreboard testbench for core_c1_dmem_arb
module tb_core_c1_dmem_arb;
  import core_c1_pkg::*;

  localparam int STARVE_MAX = 8;
  localparam int NTXN       = 150;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_mem_req, exu_mem_we;
  logic [31:0] exu_mem_addr, exu_mem_wdata;
  logic [1:0]  exu_mem_size;
  logic [31:0] exu_mem_rdata;
  logic        exu_pause;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic [1:0]  ext_size;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;

  core_c1_dmem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_mem_req(exu_mem_req), .exu_mem_we(exu_mem_we), .exu_mem_addr(exu_mem_addr),
    .exu_mem_wdata(exu_mem_wdata), .exu_mem_size(exu_mem_size),
    .exu_mem_rdata(exu_mem_rdata), .exu_pause(exu_pause),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_size(ext_size), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory with one-cycle read latency; word granular
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr[8:2]] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata = mem[mem_addr[8:2]];
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } strobe_t;

  strobe_t     exu_sq[$];
  strobe_t     ext_sq[$];
  logic [31:0] exu_rd_q[$];
  logic [31:0] ext_rd_q[$];
  logic [31:0] shadow [0:127];

  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ext_gnt(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ext_gnt) begin
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or read data
  initial begin
    bit prev_rd = 1'b0;
    int refused = 0;
    strobe_t e;
    forever begin
      @(negedge clk);
      if (sb_on && rst_n) begin
        if (prev_rd) chk("port_idle_after_read", {31'd0, mem_en}, 32'd0);
        prev_rd = mem_en && !mem_we;
        if (mem_en) begin
          if (mem_addr[8] ? (ext_sq.size() == 0) : (exu_sq.size() == 0)) begin
            chk("unexpected_strobe", mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = mem_addr[8] ? ext_sq.pop_front() : exu_sq.pop_front();
            chk("strobe_we", {31'd0, mem_we}, {31'd0, e.we});
            chk("strobe_addr", mem_addr, e.addr);
            chk("strobe_wdata", mem_wdata, e.wdata);
            chk("strobe_size", {30'd0, mem_size}, {30'd0, e.size});
          end
        end
        if (exu_mem_req && !exu_mem_we && !exu_pause) begin
          if (exu_rd_q.size() == 0) chk("exu_unexpected_load_done", 32'd1, 32'd0);
          else chk("exu_load_data", exu_mem_rdata, exu_rd_q.pop_front());
        end else begin
          chk("exu_rdata_idle_zero", exu_mem_rdata, 32'd0);
        end
        if (ext_rvalid) begin
          if (ext_rd_q.size() == 0) chk("ext_unexpected_rvalid", 32'd1, 32'd0);
          else chk("ext_read_data", ext_rdata, ext_rd_q.pop_front());
        end else begin
          chk("ext_rdata_idle_zero", ext_rdata, 32'd0);
        end
        if (ext_req) begin
          if (ext_gnt) begin
            chk("starve_bound", {31'd0, refused <= STARVE_MAX + 1}, 32'd1);
            refused = 0;
          end else begin
            refused++;
          end
        end else begin
          refused = 0;
        end
      end else begin
        prev_rd = 1'b0;
        refused = 0;
      end
    end
  end

  task automatic exu_driver();
    for (int t = 0; t < NTXN; t++) begin
      strobe_t s;
      logic [6:0] idx;
      bit done = 1'b0;
      idx     = 7'($urandom_range(0, 63));
      s.we    = 1'($urandom_range(0, 1));
      s.addr  = {23'd0, idx, 2'b00};
      s.wdata = $urandom;
      s.size  = 2'($urandom_range(0, 2));
      exu_sq.push_back(s);
      if (s.we) shadow[idx] = s.wdata;
      else exu_rd_q.push_back(shadow[idx]);
      exu_mem_req = 1'b1; exu_mem_we = s.we; exu_mem_addr = s.addr;
      exu_mem_wdata = s.wdata; exu_mem_size = s.size;
      for (int n = 0; n < 50 && !done; n++) begin
        @(negedge clk);
        if (!exu_pause) done = 1'b1;
        else tick();
      end
      if (!done) chk("exu_completion_timeout", 32'd0, 32'd1);
      tick();
      exu_mem_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic ext_driver();
    for (int t = 0; t < NTXN; t++) begin
      strobe_t s;
      logic [6:0] idx;
      bit done = 1'b0;
      idx     = 7'($urandom_range(64, 127));
      s.we    = 1'($urandom_range(0, 1));
      s.addr  = {23'd0, idx, 2'b00};
      s.wdata = $urandom;
      s.size  = 2'($urandom_range(0, 2));
      ext_sq.push_back(s);
      if (s.we) shadow[idx] = s.wdata;
      else ext_rd_q.push_back(shadow[idx]);
      ext_req = 1'b1; ext_we = s.we; ext_addr = s.addr;
      ext_wdata = s.wdata; ext_size = s.size;
      for (int n = 0; n < 50 && !done; n++) begin
        @(negedge clk);
        if (ext_gnt) done = 1'b1;
        else tick();
      end
      if (!done) chk("ext_grant_timeout", 32'd0, 32'd1);
      tick();
      ext_req = 1'b0;
      repeat ($urandom_range(0, 4)) tick();
    end
  endtask

  initial begin
    int gcyc;
    int en_cnt;
    rst_n = 1'b0;
    exu_mem_req = 0; exu_mem_we = 0; exu_mem_addr = 0; exu_mem_wdata = 0; exu_mem_size = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_size = 0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("rst_exu_pause", {31'd0, exu_pause}, 32'd0);

    // EXU store: single cycle, no pause
    tick();
    exu_mem_req = 1; exu_mem_we = 1; exu_mem_addr = 32'h100;
    exu_mem_wdata = 32'hDEADBEEF; exu_mem_size = SZ_W;
    @(negedge clk);
    chk("st_mem_en", {31'd0, mem_en}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h100);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_pause", {31'd0, exu_pause}, 32'd0);
    tick();
    exu_mem_req = 0;

    // EXU load: pause at N, data at N+1, one strobe
    mem[0] = 32'h12345678;
    tick();
    exu_mem_req = 1; exu_mem_we = 0; exu_mem_addr = 32'h200;
    @(negedge clk);
    en_cnt = int'(mem_en);
    chk("ld_pause_n", {31'd0, exu_pause}, 32'd1);
    chk("ld_mem_we_n", {31'd0, mem_we}, 32'd0);
    tick();
    @(negedge clk);
    en_cnt += int'(mem_en);
    chk("ld_pause_n1", {31'd0, exu_pause}, 32'd0);
    chk("ld_rdata", exu_mem_rdata, 32'h12345678);
    chk("ld_one_strobe", en_cnt, 32'd1);
    tick();
    exu_mem_req = 0;

    // External read while EXU idle
    mem[16] = 32'hCAFEF00D;
    tick();
    ext_req = 1; ext_we = 0; ext_addr = 32'h40; ext_size = SZ_W;
    @(negedge clk);
    chk("xr_gnt", {31'd0, ext_gnt}, 32'd1);
    chk("xr_mem_addr", mem_addr, 32'h40);
    tick();
    ext_req = 0;
    @(negedge clk);
    chk("xr_rvalid", {31'd0, ext_rvalid}, 32'd1);
    chk("xr_rdata", ext_rdata, 32'hCAFEF00D);
    chk("xr_gnt_gone", {31'd0, ext_gnt}, 32'd0);

    // Starvation under continuous EXU stores
    tick();
    exu_mem_req = 1; exu_mem_we = 1; exu_mem_addr = 32'h104; exu_mem_wdata = 32'h5555AAAA;
    ext_req = 1; ext_we = 1; ext_addr = 32'h1F0; ext_wdata = 32'h0BADCAFE;
    wait_ext_gnt(gcyc);
    chk("starve_gnt_cycle", gcyc, 32'd9);
    chk("starve_exu_paused", {31'd0, exu_pause}, 32'd1);
    chk("starve_port_ext", mem_addr, 32'h1F0);
    // Both requesting right after the grant: counter is back at zero, EXU wins
    tick();
    @(negedge clk);
    chk("both_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    chk("both_exu_pause", {31'd0, exu_pause}, 32'd0);
    chk("both_port_exu", mem_addr, 32'h104);
    tick();
    wait_ext_gnt(gcyc);
    chk("starve_regnt_cycle", gcyc, 32'd8);
    tick();
    exu_mem_req = 0; ext_req = 0;

    // Reset during the external read-data cycle
    tick();
    ext_req = 1; ext_we = 0; ext_addr = 32'h40;
    @(negedge clk);
    chk("rr_gnt", {31'd0, ext_gnt}, 32'd1);
    tick();
    ext_req = 0;
    rst_n = 0;
    @(negedge clk);
    chk("rr_rvalid", {31'd0, ext_rvalid}, 32'd0);
    chk("rr_rdata", ext_rdata, 32'd0);
    chk("rr_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rr_ext_gnt", {31'd0, ext_gnt}, 32'd0);
    tick();
    rst_n = 1;
    exu_mem_req = 1; exu_mem_we = 1; exu_mem_addr = 32'h108; exu_mem_wdata = 32'h77;
    @(negedge clk);
    chk("rr_post_grant", {31'd0, mem_en}, 32'd1);
    chk("rr_post_addr", mem_addr, 32'h108);
    chk("rr_post_rvalid", {31'd0, ext_rvalid}, 32'd0);
    tick();
    exu_mem_req = 0;

    // Randomized concurrent traffic checked by the scoreboard
    for (int i = 0; i < 128; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    tick();
    sb_on = 1'b1;
    fork
      exu_driver();
      ext_driver();
    join
    repeat (4) tick();
    sb_on = 1'b0;
    chk("exu_strobes_left", exu_sq.size(), 32'd0);
    chk("ext_strobes_left", ext_sq.size(), 32'd0);
    chk("exu_reads_left", exu_rd_q.size(), 32'd0);
    chk("ext_reads_left", ext_rd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_c1_dmem_arb.md
# core_c1_dmem_arb

Data-memory port arbiter and access sequencer for the C1 core. It shares the single synchronous data-memory port between the execute unit's load/store path and one external requester (debug/DMA). It sequences the one-cycle read latency of the memory and generates the execute-stage pause signal that holds an instruction until its memory access completes.

## Interface
- STARVE_MAX, 8: consecutive cycles an external request may be refused before it wins over the EXU (1..255).
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- exu_mem_req  in  1  EXU load or store valid; held stable while exu_pause=1
- exu_mem_we  in  1  1=store, 0=load
- exu_mem_addr  in  32  byte address
- exu_mem_wdata  in  32  store data
- exu_mem_size  in  2  0=byte, 1=half, 2=word
- exu_mem_rdata  out  32  load data, valid in the load-completion cycle
- exu_pause  out  1  stall to EXU (suppresses writeback, holds PC)
- ext_req  in  1  external access request; held until ext_gnt
- ext_we, ext_addr, ext_wdata, ext_size  in  1/32/32/2  as EXU fields
- ext_gnt  out  1  one-cycle accept pulse
- ext_rvalid  out  1  read data valid, one cycle
- ext_rdata  out  32  read data
- mem_en, mem_we  out  1  port strobe / write enable
- mem_addr, mem_wdata  out  32  port address / write data
- mem_size  out  2  port access size
- mem_rdata  in  32  read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE (port free), RD_EXU (EXU read data returning), RD_EXT (external read data returning).
- IDLE arbitration, in this order:
  - ext_req && (starve_cnt==STARVE_MAX || !exu_mem_req): grant external.
  - otherwise exu_mem_req: grant EXU.
  - otherwise no strobe.
- Grant drives mem_* combinationally from the winner with mem_en=1.
- Write grant completes in the same cycle; FSM stays IDLE.
- Read grant moves the FSM to RD_EXU or RD_EXT.
- RD_* cycle: mem_en=0 (no issue); route mem_rdata to exu_mem_rdata or to ext_rdata with ext_rvalid=1; return to IDLE.
- exu_pause = exu_mem_req && !(EXU store granted this cycle || state==RD_EXU).
- ext_gnt = 1 in the external grant cycle.
- starve_cnt, width clog2(STARVE_MAX+1):
  - clears on ext_gnt;
  - increments, saturating at STARVE_MAX, on each cycle with ext_req && !ext_gnt;
  - holds otherwise.
- Unselected rdata outputs drive 0.

## Timing
- Reset values: state=IDLE, starve_cnt=0, mem_en=0, mem_we=0, ext_gnt=0, ext_rvalid=0. exu_pause=0 while exu_mem_req=0.
- EXU store: 1 cycle, pause 0 when granted.
- EXU load: 2 cycles. Cycle N grant with pause=1; cycle N+1 data with pause=0. The held request in N+1 is not reissued.
- External write: gnt in grant cycle. External read: gnt at N, rvalid at N+1.
- Back-to-back EXU loads: new issue every 2 cycles. Port idle in RD_* cycles, so requests arriving then wait for IDLE.
- Starvation: after STARVE_MAX refused cycles the external request wins the next IDLE cycle; EXU sees pause=1 for that access (1 cycle write, 2 cycles read) and is then re-arbitrated.
- Simultaneous EXU and external requests with starve_cnt<STARVE_MAX: EXU wins.
- Reset mid-read: in-flight read is dropped, no rvalid/data delivered, counter cleared.

## Structure
- Package core_c1_pkg holds:
  - FSM state encoding (2-bit localparams IDLE=0, RD_EXU=1, RD_EXT=2);
  - memory size encodings SZ_B/SZ_H/SZ_W.
- Single flat module; the starvation counter and the FSM live in one always block each. No sub-module.

## Test plan
- EXU store 0x0000_0100, word 0xDEADBEEF, no ext: mem_en=mem_we=1 same cycle, exu_pause=0.
- EXU load 0x0000_0200 (mem returns 0x1234_5678): pause=1 at N, exu_mem_rdata=0x12345678 with pause=0 at N+1, exactly one mem_en.
- ext read 0x40 while EXU idle: ext_gnt at N, ext_rvalid=1 and ext_rdata=mem_rdata at N+1.
- EXU issues continuous stores with ext_req held, STARVE_MAX=8: ext_gnt at cycle 9, EXU paused that cycle, starve_cnt back to 0.
- Both request same cycle, cnt=0: EXU granted, ext_gnt=0, cnt=1.
- rst_n low in RD_EXT cycle: ext_rvalid stays 0, state IDLE, all outputs at reset values; normal grant on first cycle after release.
